// File: rtl/rr_fifo_arbiter.sv
// Round-robin drain stage between four upstream class FIFOs and four
// downstream FIFOs. Each cycle it pops at most one non-empty source,
// starting the search at rr_ptr. It captures the word the source presents
// one cycle later and pushes it to the downstream FIFO named by the word's
// two MSBs. Popping stops globally while any downstream FIFO is almost full.
// The up to two words already in flight always complete.
//
// Handshake: src_pop[i] is a combinational read strobe. The upstream FIFO
// presents the popped word on its src_data lane during the following cycle.
// dst_push[d] is a registered one-cycle write strobe qualified by data_out.
// Downstream has no ready, so its almost-full threshold must leave at least
// two free entries.
//
// Optional feature: define ARB_CNT_EN to add per-destination push counters
// on the push_cnt port.
module rr_fifo_arbiter #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             src_empty,
  input  logic [4*DATA_SIZE-1:0] src_data,
  input  logic [3:0]             dst_almost_full,
  output logic [3:0]             src_pop,
  output logic [3:0]             dst_push,
  output logic [DATA_SIZE-1:0]   data_out,
`ifdef ARB_CNT_EN
  output logic [4*CNT_W-1:0]     push_cnt,
`endif
  output logic                   idle
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [1:0]           rr_ptr;
  logic [1:0]           grant;
  logic                 grant_ok;
  logic                 pop_fire;
  logic                 pend_valid;
  logic [1:0]           pend_src;
  logic [DATA_SIZE-1:0] pend_word;

  // Next state (pause wins), round-robin grant and the pop strobe.
  always_comb begin
    logic [1:0] idx;
    state_next = ST_IDLE;
    grant      = 2'd0;
    grant_ok   = 1'b0;
    src_pop    = 4'b0000;
    pop_fire   = 1'b0;
    idx        = 2'd0;
    if (|dst_almost_full) begin
      state_next = ST_PAUSE;
    end else if (!(&src_empty)) begin
      state_next = ST_ACTIVE;
    end
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!grant_ok && !src_empty[idx]) begin
        grant    = idx;
        grant_ok = 1'b1;
      end
    end
    if (state_next == ST_ACTIVE && grant_ok && !reset) begin
      pop_fire       = 1'b1;
      src_pop[grant] = 1'b1;
    end
  end

  // Select the lane of the source popped last cycle.
  always_comb begin
    pend_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (pend_src == 2'(i)) begin
        pend_word = src_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  // FSM state, round-robin pointer and the pop-to-capture stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= 2'd0;
      pend_valid <= 1'b0;
      pend_src   <= 2'd0;
    end else begin
      state      <= state_next;
      pend_valid <= pop_fire;
      if (pop_fire) begin
        pend_src <= grant;
        rr_ptr   <= grant + 2'd1;
      end
    end
  end

  // Capture the presented word and strobe the destination named by its class.
  always_ff @(posedge clk) begin
    if (reset) begin
      dst_push <= 4'b0000;
      data_out <= '0;
    end else if (pend_valid) begin
      data_out <= pend_word;
      dst_push <= 4'b0001 << pend_word[DATA_SIZE-1 -: 2];
    end else begin
      dst_push <= 4'b0000;
    end
  end

  // Idle is decoded purely from flops: idle state, nothing pending, no push.
  always_comb begin
    idle = (state == ST_IDLE) && !pend_valid && (dst_push == 4'b0000);
  end

`ifdef ARB_CNT_EN
  logic [CNT_W-1:0] cnt [4];

  // Per-destination push counters, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < 4; d++) cnt[d] <= '0;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (dst_push[d]) cnt[d] <= cnt[d] + 1'b1;
      end
    end
  end

  for (genvar d = 0; d < 4; d++) begin : g_cnt
    assign push_cnt[d*CNT_W +: CNT_W] = cnt[d];
  end
`endif

endmodule
